// File: rtl/mips_pkg.sv
//==============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS fetch stage.
//               Provides the fetch FSM state encoding, the NOP encoding and
//               the default reset PC.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mips_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

   // Branch targets are word addresses; the low two bits are ignored.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
//==============================================================================
// Module      : fetch_skid_buffer
// Description : One-entry {instruction, pc} store that catches a fetch which
//               completes while decode is stalled.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous reset, active-low
//               i_load    - capture i_instr / i_pc, mark full
//               i_unload  - entry consumed, mark empty
//               i_clear   - entry dropped (redirect), mark empty
//               i_instr   - instruction to capture
//               i_pc      - address of i_instr
//               o_instr   - stored instruction
//               o_pc      - stored address
//               o_full    - entry holds valid data
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_skid_buffer
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_unload,
   input  logic               i_clear,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [INSTR_W-1:0] i_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic [INSTR_W-1:0] o_pc,
   output logic               o_full
);

   logic [INSTR_W-1:0] r_instr;
   logic [INSTR_W-1:0] r_pc;
   logic               r_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_instr <= NOP_INSTR;
         r_pc    <= '0;
         r_full  <= 1'b0;
      end else begin
         if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_full  <= 1'b1;
         end else if (i_unload || i_clear) begin
            r_full  <= 1'b0;
         end
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_full  = r_full;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//==============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, fetches words over a
//               req/ack handshake, applies branch redirects and stalls, and
//               drives the IF/ID pipeline register.
// Ports       : clk            - clock, rising edge
//               rst            - asynchronous reset, active-low
//               en             - fetch enable (0 = no new requests)
//               imem_req       - fetch request
//               imem_addr      - fetch address (= pc)
//               imem_ack       - memory returns data this cycle
//               imem_rdata     - instruction word
//               stall          - decode cannot accept
//               branch_taken   - redirect request (beats stall and en)
//               branch_target  - redirect address (low bits ignored)
//               if_id_valid    - IF/ID holds a live instruction
//               if_id_instr    - fetched instruction
//               if_id_pc       - address of if_id_instr
//               if_id_pc_plus4 - if_id_pc + 4
//               pc             - next fetch address
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DATA_W   = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   output logic              if_id_valid,
   output logic [DATA_W-1:0] if_id_instr,
   output logic [DATA_W-1:0] if_id_pc,
   output logic [DATA_W-1:0] if_id_pc_plus4,
   output logic [DATA_W-1:0] pc
);

   fetch_state_e r_state, w_state_nxt;

   logic [DATA_W-1:0] r_pc,          w_pc_nxt;
   logic [DATA_W-1:0] r_redirect_pc, w_redirect_nxt;
   logic              r_valid,       w_valid_nxt;
   logic [DATA_W-1:0] r_instr,       w_instr_nxt;
   logic [DATA_W-1:0] r_id_pc,       w_id_pc_nxt;
   logic [DATA_W-1:0] r_id_pc4,      w_id_pc4_nxt;

   logic              w_skid_load, w_skid_unload, w_skid_clear, w_skid_full;
   logic [DATA_W-1:0] w_skid_instr, w_skid_pc;

   logic [DATA_W-1:0] w_target;
   logic [DATA_W-1:0] w_pc_plus4;

   assign w_target   = word_align(branch_target);
   assign w_pc_plus4 = r_pc + 32'd4;   // wraps modulo 2^32

   fetch_skid_buffer u_skid (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_skid_load),
      .i_unload (w_skid_unload),
      .i_clear  (w_skid_clear),
      .i_instr  (imem_rdata),
      .i_pc     (r_pc),
      .o_instr  (w_skid_instr),
      .o_pc     (w_skid_pc),
      .o_full   (w_skid_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc          <= RESET_PC;
         r_redirect_pc <= '0;
         r_valid       <= 1'b0;
         r_instr       <= NOP_INSTR;
         r_id_pc       <= '0;
         r_id_pc4      <= '0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_redirect_pc <= w_redirect_nxt;
         r_valid       <= w_valid_nxt;
         r_instr       <= w_instr_nxt;
         r_id_pc       <= w_id_pc_nxt;
         r_id_pc4      <= w_id_pc4_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_redirect_nxt = r_redirect_pc;
      w_valid_nxt    = r_valid;
      w_instr_nxt    = r_instr;
      w_id_pc_nxt    = r_id_pc;
      w_id_pc4_nxt   = r_id_pc4;
      w_skid_load    = 1'b0;
      w_skid_unload  = 1'b0;
      w_skid_clear   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (en)           w_state_nxt = ST_FETCH;
            if (branch_taken) w_pc_nxt    = w_target;
            if (!stall)       w_valid_nxt = 1'b0;
         end

         ST_FETCH: begin
            if (branch_taken && imem_ack) begin
               // Returned word belongs to the wrong path: drop it.
               w_pc_nxt    = w_target;
               w_valid_nxt = 1'b0;
               w_state_nxt = en ? ST_FETCH : ST_IDLE;
            end else if (branch_taken) begin
               // Request in flight: keep the address stable until it
               // is acked, and remember where to go afterwards.
               w_redirect_nxt = w_target;
               w_valid_nxt    = 1'b0;
               w_state_nxt    = ST_DRAIN;
            end else if (imem_ack && !stall) begin
               w_instr_nxt  = imem_rdata;
               w_id_pc_nxt  = r_pc;
               w_id_pc4_nxt = w_pc_plus4;
               w_valid_nxt  = 1'b1;
               w_pc_nxt     = w_pc_plus4;
               w_state_nxt  = en ? ST_FETCH : ST_IDLE;
            end else if (imem_ack) begin
               w_skid_load = 1'b1;
               w_pc_nxt    = w_pc_plus4;
               w_state_nxt = ST_HOLD;
            end else if (!stall) begin
               w_valid_nxt = 1'b0;
            end
         end

         ST_HOLD: begin
            if (branch_taken) begin
               w_skid_clear = 1'b1;
               w_valid_nxt  = 1'b0;
               w_pc_nxt     = w_target;
               w_state_nxt  = en ? ST_FETCH : ST_IDLE;
            end else if (!stall && w_skid_full) begin
               w_skid_unload = 1'b1;
               w_instr_nxt   = w_skid_instr;
               w_id_pc_nxt   = w_skid_pc;
               w_id_pc4_nxt  = w_skid_pc + 32'd4;
               w_valid_nxt   = 1'b1;
               w_state_nxt   = en ? ST_FETCH : ST_IDLE;
            end
         end

         ST_DRAIN: begin
            if (branch_taken) w_redirect_nxt = w_target;
            if (imem_ack) begin
               // A redirect arriving on the ack cycle is the latest one.
               w_pc_nxt    = branch_taken ? w_target : r_redirect_pc;
               w_state_nxt = ST_FETCH;
            end
            if (!stall) w_valid_nxt = 1'b0;
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign imem_req       = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
   assign imem_addr      = r_pc;
   assign pc             = r_pc;
   assign if_id_valid    = r_valid;
   assign if_id_instr    = r_instr;
   assign if_id_pc       = r_id_pc;
   assign if_id_pc_plus4 = r_id_pc4;

endmodule

`default_nettype wire
